// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared state encoding and sweep constants for the adder BIST
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

endpackage

// File: rtl/adder_bist_ref.sv
// rtl/adder_bist_ref.sv - golden 1-bit full adder used to judge the sampled S/Cout
module adder_bist_ref (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s_exp,
    output logic cout_exp
);

    assign s_exp    = a ^ b ^ cin;
    assign cout_exp = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - sweeps all 8 full-adder input vectors and records mismatches
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    input  logic             p1,
    input  logic             p2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_vec
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   fail_q, fail_d;

    logic s_exp;
    logic cout_exp;
    logic mismatch;
    logic launch;

    adder_bist_ref u_ref (
        .a        (vec_q[2]),
        .b        (vec_q[1]),
        .cin      (vec_q[0]),
        .s_exp    (s_exp),
        .cout_exp (cout_exp)
    );

    // One mismatch per vector regardless of how many adder outputs are wrong.
    assign mismatch = (p1 != s_exp) || (p2 != cout_exp);
    assign launch   = ((state_q == IDLE) || (state_q == DONE)) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (settle_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (vec_q == VEC_LAST) ? DONE : DRIVE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        if (launch) begin
            vec_d    = '0;
            settle_d = '0;
            err_d    = '0;
            fail_d   = '0;
        end else if (state_q == DRIVE) begin
            settle_d = settle_q + SET_W'(1);
        end else if (state_q == SAMPLE) begin
            if (mismatch) begin
                fail_d[vec_q] = 1'b1;
                if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            end
            if (vec_q != VEC_LAST) begin
                vec_d    = vec_q + VEC_W'(1);
                settle_d = '0;
            end
        end
    end

    always_comb begin
        busy         = (state_q == DRIVE) || (state_q == SAMPLE);
        done         = (state_q == DONE);
        {t1, t2, t3} = busy ? vec_q : '0;
        pass         = done && (err_q == '0);
        err_cnt      = err_q;
        fail_vec     = fail_q;
    end

endmodule
